fixed_to_ascii: RTL



---
 rtl/fixed_pkg.sv | 28 ++
 rtl/fixed_to_ascii_if.sv | 23 ++
 rtl/fixed_bcd_dabble.sv | 70 +++++++
 rtl/fixed_to_ascii.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point format definitions: word geometry, ASCII constants and
// the emit-sequence states used by the fixed-to-ASCII printer.
package fixed_pkg;

    localparam int B = 20;
    localparam int D = 8;
    localparam int IW = B - D;
    localparam int NDIG = ((IW + 1) * 10 + 32) / 33;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FCW = $clog2(D + 1);

    typedef logic signed [B-1:0] fixed;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_SIGN,
        ST_INT,
        ST_DOT,
        ST_FRAC,
        ST_TERM
    } emit_state_e;

endpackage

// File: rtl/fixed_to_ascii_if.sv
// Value-in / byte-out handshake bundle for the fixed-to-ASCII printer.
interface fixed_to_ascii_if;
    import fixed_pkg::*;

    fixed       val;
    logic       valValid;
    logic       valReady;
    logic [7:0] byteData;
    logic       byteValid;
    logic       byteReady;
    logic       last;

    modport master (
        output val, valValid, byteReady,
        input  valReady, byteData, byteValid, last
    );

    modport slave (
        input  val, valValid, byteReady,
        output valReady, byteData, byteValid, last
    );

endinterface

// File: rtl/fixed_bcd_dabble.sv
// Sequential shift-and-add-3 binary to BCD converter; the first bit is shifted
// on the start edge so a W-bit value is finished W cycles after start.
module fixed_bcd_dabble #(
    parameter int W = 12,
    localparam int NDIG = ((W + 1) * 10 + 32) / 33,
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_i,
    input  logic [W-1:0]        bin_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [4*NDIG-1:0]   bcd_o,
    output logic [IDX_W-1:0]    msd_o
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]      bin_q;
    logic [4*NDIG-1:0] bcd_q;
    logic [4*NDIG-1:0] adj;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i << 1;
            bcd_q  <= {{(4*NDIG-1){1'b0}}, bin_i[W-1]};
            cnt_q  <= CNT_W'(W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            bin_q <= bin_q << 1;
            bcd_q <= (adj << 1) | {{(4*NDIG-1){1'b0}}, bin_q[W-1]};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                done_q <= 1'b1;
            end
        end
    end

    // Highest nonzero digit wins; an all-zero value reports digit 0.
    always_comb begin
        msd_o = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd_o = IDX_W'(i);
            end
        end
    end

    assign busy_o = (cnt_q != '0);
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/fixed_to_ascii.sv
// Prints one signed fixed-point value as a decimal ASCII string, one byte per
// valid/ready transfer, with optional fraction digits and terminator.
module fixed_to_ascii
    import fixed_pkg::*;
#(
    parameter int         FRAC_DIGITS = 3,
    parameter bit         TERM_EN     = 1'b1,
    parameter logic [7:0] TERM_CHAR   = 8'h0A
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  fixed       val_in,
    input  logic       val_valid_in,
    output logic       val_ready_out,
    output logic [7:0] byte_out,
    output logic       byte_valid_out,
    input  logic       byte_ready_in,
    output logic       last_out
);

    emit_state_e      state_q, state_d;
    logic             sign_q;
    logic [D-1:0]     frac_q, frac_d;
    logic [IDX_W-1:0] intIdx_q, intIdx_d;
    logic [FCW-1:0]   fracCnt_q, fracCnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, last_q, last_d;

    logic [B-1:0]       mag;
    logic               accept;
    logic               advance;
    logic               dabBusy, dabDone;
    logic [4*NDIG-1:0]  dabBcd;
    logic [IDX_W-1:0]   dabMsd;
    logic [D+3:0]       fracX10;
    logic               goInt, goAfterInt, goAfterFrac;
    logic [IDX_W-1:0]   intFrom;

    assign mag           = val_in[B-1] ? (~val_in + 1'b1) : val_in;
    assign val_ready_out = (state_q == ST_IDLE) && rst_n_in;
    assign accept        = val_valid_in && val_ready_out;
    assign advance       = (state_q == ST_CONV) ? (dabDone && !dabBusy)
                                                : (valid_q && byte_ready_in);
    assign fracX10       = {1'b0, frac_q, 3'b000} + {3'b000, frac_q, 1'b0};

    fixed_bcd_dabble #(.W(IW)) u_dabble (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start_i  (accept),
        .bin_i    (mag[B-1:D]),
        .busy_o   (dabBusy),
        .done_o   (dabDone),
        .bcd_o    (dabBcd),
        .msd_o    (dabMsd)
    );

    // Work out the byte that follows the one currently presented.
    always_comb begin
        state_d     = ST_IDLE;
        byte_d      = '0;
        last_d      = 1'b0;
        intIdx_d    = intIdx_q;
        fracCnt_d   = fracCnt_q;
        frac_d      = frac_q;
        goInt       = 1'b0;
        goAfterInt  = 1'b0;
        goAfterFrac = 1'b0;
        intFrom     = dabMsd;
        case (state_q)
            ST_CONV: begin
                if (sign_q) begin
                    state_d = ST_SIGN;
                    byte_d  = ASCII_MINUS;
                end else begin
                    goInt = 1'b1;
                end
            end
            ST_SIGN: goInt = 1'b1;
            ST_INT: begin
                if (intIdx_q != '0) begin
                    goInt   = 1'b1;
                    intFrom = intIdx_q - IDX_W'(1);
                end else begin
                    goAfterInt = 1'b1;
                end
            end
            ST_DOT, ST_FRAC: begin
                if (state_q == ST_DOT || fracCnt_q != '0) begin
                    state_d   = ST_FRAC;
                    byte_d    = ASCII_0 + {4'b0000, fracX10[D+3:D]};
                    frac_d    = fracX10[D-1:0];
                    fracCnt_d = (state_q == ST_DOT) ? FCW'(FRAC_DIGITS - 1)
                                                    : fracCnt_q - FCW'(1);
                    last_d    = (fracCnt_d == '0) && !TERM_EN;
                end else begin
                    goAfterFrac = 1'b1;
                end
            end
            default: ;
        endcase

        if (goInt) begin
            state_d  = ST_INT;
            intIdx_d = intFrom;
            byte_d   = ASCII_0 + {4'b0000, dabBcd[4*intFrom +: 4]};
            last_d   = (intFrom == '0) && (FRAC_DIGITS == 0) && !TERM_EN;
        end
        if (goAfterInt) begin
            if (FRAC_DIGITS > 0) begin
                state_d = ST_DOT;
                byte_d  = ASCII_DOT;
            end else if (TERM_EN) begin
                state_d = ST_TERM;
                byte_d  = TERM_CHAR;
                last_d  = 1'b1;
            end
        end
        if (goAfterFrac && TERM_EN) begin
            state_d = ST_TERM;
            byte_d  = TERM_CHAR;
            last_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            frac_q    <= '0;
            intIdx_q  <= '0;
            fracCnt_q <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                state_q <= ST_CONV;
                sign_q  <= val_in[B-1] && (mag != '0);
                frac_q  <= mag[D-1:0];
            end
        end else if (advance) begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            last_q    <= last_d;
            valid_q   <= (state_d != ST_IDLE);
            intIdx_q  <= intIdx_d;
            fracCnt_q <= fracCnt_d;
            frac_q    <= frac_d;
        end
    end

    assign byte_out       = byte_q;
    assign byte_valid_out = valid_q;
    assign last_out       = last_q;

endmodule
